// File: rtl/scsi_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scsi_fifo_pkg
//  Purpose  : Shared defaults, byte-lane constants and lane helper for the
//             SCSI longword FIFO.
//  Contents : c_DEPTH_DEF / c_AW_DEF  default depth and pointer width
//             c_BO_W                  byte pointer width
//             c_LANE_HI_0..3          high-bit offset of each byte lane
//             lane_sel()              byte pointer -> high-bit offset
//  Revision : 1.0  initial release
// ============================================================================
package scsi_fifo_pkg;

    localparam int c_DEPTH_DEF = 8;
    localparam int c_AW_DEF    = 3;
    localparam int c_BO_W      = 2;

    // Big-endian 68k lane order: byte pointer 0 is the most significant byte.
    localparam logic [4:0] c_LANE_HI_0 = 5'd31;
    localparam logic [4:0] c_LANE_HI_1 = 5'd23;
    localparam logic [4:0] c_LANE_HI_2 = 5'd15;
    localparam logic [4:0] c_LANE_HI_3 = 5'd7;

    function automatic logic [4:0] lane_sel(input logic [c_BO_W-1:0] bo);
        logic [4:0] hi;
        hi = c_LANE_HI_0;
        case (bo)
            2'd0:    hi = c_LANE_HI_0;
            2'd1:    hi = c_LANE_HI_1;
            2'd2:    hi = c_LANE_HI_2;
            default: hi = c_LANE_HI_3;
        endcase
        return hi;
    endfunction

endpackage : scsi_fifo_pkg
`default_nettype wire

// File: rtl/scsi_fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : scsi_fifo_ptr
//  Purpose  : Next-in / next-out pointers, entry count, full/empty decode and
//             protocol error detection for the SCSI longword FIFO.
//  Ports    : clk        clock (rising edge)
//             rst        synchronous active-high reset
//             i_flush    synchronous clear of pointers, count and error
//             i_inc_ni   commit entry at NI
//             i_inc_no   release entry at NO
//             i_wr_req   a data write is being requested this cycle
//             o_ni/o_no  current pointers
//             o_full     count == DEPTH
//             o_empty    count == 0
//             o_err      sticky protocol error
//  Options  : SCSI_FIFO_ERR_EN  enables the error detector; otherwise o_err=0
//  Revision : 1.0  initial release
// ============================================================================
module scsi_fifo_ptr
    import scsi_fifo_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEF,
    parameter int AW    = c_AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_inc_ni,
    input  logic          i_inc_no,
    input  logic          i_wr_req,
    output logic [AW-1:0] o_ni,
    output logic [AW-1:0] o_no,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_err
);

    localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] r_ni;
    logic [AW-1:0] r_no;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_do_ni;
    logic w_do_no;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);

    // Each request is judged against the pre-edge count; this alone yields the
    // simultaneous rules (empty: only NI moves, full: only NO moves).
    assign w_do_ni = i_inc_ni & ~w_full;
    assign w_do_no = i_inc_no & ~w_empty;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_ni    <= '0;
            r_no    <= '0;
            r_count <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH == 2**AW.
            if (w_do_ni) r_ni <= r_ni + 1'b1;
            if (w_do_no) r_no <= r_no + 1'b1;
            case ({w_do_ni, w_do_no})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SCSI_FIFO_ERR_EN
    logic r_err;
    logic w_err_evt;

    assign w_err_evt = (i_inc_ni & w_full  & ~i_inc_no) |
                       (i_inc_no & w_empty & ~i_inc_ni) |
                       (i_wr_req & w_full);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    logic w_unused_wr_req;
    assign w_unused_wr_req = i_wr_req;
    assign o_err = 1'b0;
`endif

    assign o_ni    = r_ni;
    assign o_no    = r_no;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule : scsi_fifo_ptr
`default_nettype wire

// File: rtl/scsi_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : scsi_fifo
//  Purpose  : Longword data FIFO between the SCSI DMA state machine and the
//             host/DMA bus. Packs SCSI bytes into 32-bit entries and presents
//             entries (or the byte lane selected by BO) for the reverse path.
//  Ports    : CPUCLK     clock (rising edge)
//             RESET      synchronous active-high reset
//             FLUSH      synchronous clear of pointers, count, BO, error
//             INCBO      advance byte pointer (mod 4)
//             INCNI      commit entry at NI
//             INCNO      release entry at NO
//             LBYTE_     active-low byte write into lane BO of entry NI
//             LHOST      longword write into entry NI (wins over LBYTE_)
//             SCSI_DIN   byte from SCSI IC
//             HOST_DIN   longword from CPU/DMA bus
//             HOST_DOUT  entry at NO
//             SCSI_DOUT  lane BO of entry NO
//             BOEQ3      BO == 3
//             FIFOFULL   count == DEPTH
//             FIFOEMPTY  count == 0
//             FIFO_ERR   sticky protocol error
//  Options  : SCSI_FIFO_ERR_EN  enables FIFO_ERR; otherwise it is tied low
//  Revision : 1.0  initial release
// ============================================================================
module scsi_fifo
    import scsi_fifo_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEF,
    parameter int AW    = c_AW_DEF
) (
    input  logic        CPUCLK,
    input  logic        RESET,
    input  logic        FLUSH,
    input  logic        INCBO,
    input  logic        INCNI,
    input  logic        INCNO,
    input  logic        LBYTE_,
    input  logic        LHOST,
    input  logic [7:0]  SCSI_DIN,
    input  logic [31:0] HOST_DIN,
    output logic [31:0] HOST_DOUT,
    output logic [7:0]  SCSI_DOUT,
    output logic        BOEQ3,
    output logic        FIFOFULL,
    output logic        FIFOEMPTY,
    output logic        FIFO_ERR
);

    logic [31:0]       r_mem [DEPTH];
    logic [c_BO_W-1:0] r_bo;

    logic [AW-1:0] w_ni;
    logic [AW-1:0] w_no;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_req;
    logic          w_wr_host;
    logic          w_wr_byte;
    logic [3:0]    w_lane_we;
    logic [7:0]    w_lane_d [4];

    scsi_fifo_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ptr (
        .clk      (CPUCLK),
        .rst      (RESET),
        .i_flush  (FLUSH),
        .i_inc_ni (INCNI),
        .i_inc_no (INCNO),
        .i_wr_req (w_wr_req),
        .o_ni     (w_ni),
        .o_no     (w_no),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_err    (FIFO_ERR)
    );

    // When full NI == NO, so any write would corrupt the entry being read.
    assign w_wr_req  = LHOST | ~LBYTE_;
    assign w_wr_host = LHOST & ~w_full;
    assign w_wr_byte = ~LBYTE_ & ~LHOST & ~w_full;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign w_lane_we[g] = w_wr_host | (w_wr_byte & (r_bo == c_BO_W'(g)));
        assign w_lane_d[g]  = w_wr_host ? HOST_DIN[lane_sel(c_BO_W'(g)) -: 8] : SCSI_DIN;
    end

    // Storage is deliberately not reset; pointers define what is valid.
    always_ff @(posedge CPUCLK) begin
        for (int l = 0; l < 4; l++) begin
            if (w_lane_we[l]) begin
                r_mem[w_ni][lane_sel(c_BO_W'(l)) -: 8] <= w_lane_d[l];
            end
        end
    end

    always_ff @(posedge CPUCLK) begin
        if (RESET || FLUSH) begin
            r_bo <= '0;
        end else if (INCBO) begin
            r_bo <= r_bo + 1'b1;
        end
    end

    assign HOST_DOUT = r_mem[w_no];
    assign SCSI_DOUT = HOST_DOUT[lane_sel(r_bo) -: 8];
    assign BOEQ3     = (r_bo == 2'd3);
    assign FIFOFULL  = w_full;
    assign FIFOEMPTY = w_empty;

endmodule : scsi_fifo
`default_nettype wire

// File: tb/tb_scsi_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scsi_fifo
//  Purpose  : Directed self-checking bench for scsi_fifo (DEPTH = 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_scsi_fifo;

`ifdef SCSI_FIFO_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        CPUCLK = 1'b0;
    logic        RESET, FLUSH, INCBO, INCNI, INCNO, LBYTE_, LHOST;
    logic [7:0]  SCSI_DIN;
    logic [31:0] HOST_DIN;
    logic [31:0] HOST_DOUT;
    logic [7:0]  SCSI_DOUT;
    logic        BOEQ3, FIFOFULL, FIFOEMPTY, FIFO_ERR;

    int checks = 0;
    int errors = 0;

    scsi_fifo dut (
        .CPUCLK    (CPUCLK),
        .RESET     (RESET),
        .FLUSH     (FLUSH),
        .INCBO     (INCBO),
        .INCNI     (INCNI),
        .INCNO     (INCNO),
        .LBYTE_    (LBYTE_),
        .LHOST     (LHOST),
        .SCSI_DIN  (SCSI_DIN),
        .HOST_DIN  (HOST_DIN),
        .HOST_DOUT (HOST_DOUT),
        .SCSI_DOUT (SCSI_DOUT),
        .BOEQ3     (BOEQ3),
        .FIFOFULL  (FIFOFULL),
        .FIFOEMPTY (FIFOEMPTY),
        .FIFO_ERR  (FIFO_ERR)
    );

    always #5 CPUCLK = ~CPUCLK;

    task automatic idle();
        RESET = 0; FLUSH = 0; INCBO = 0; INCNI = 0; INCNO = 0;
        LBYTE_ = 1; LHOST = 0; SCSI_DIN = 8'h00; HOST_DIN = 32'h0;
    endtask

    // One clock edge, then settle so outputs reflect that edge's update.
    task automatic step();
        @(posedge CPUCLK);
        #1;
        idle();
    endtask

    task automatic do_reset();
        RESET = 1;
        step();
    endtask

    task automatic push(input logic [31:0] d);
        LHOST = 1; HOST_DIN = d; INCNI = 1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (FIFOEMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", FIFOEMPTY); end
        checks++; if (FIFOFULL !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", FIFOFULL); end
        checks++; if (BOEQ3 !== 1'b0) begin errors++; $display("FAIL reset_boeq3: got %b expected 0", BOEQ3); end
        checks++; if (FIFO_ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", FIFO_ERR); end
    endtask

    task automatic test_byte_pack();
        logic [7:0] b [4];
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            SCSI_DIN = b[i]; LBYTE_ = 0; INCBO = 1;
            step();
            checks++; if (BOEQ3 !== (i == 2)) begin errors++; $display("FAIL pack_boeq3[%0d]: got %b expected %b", i, BOEQ3, (i == 2)); end
        end
        INCNI = 1;
        step();
        checks++; if (HOST_DOUT !== 32'h11223344) begin errors++; $display("FAIL pack_host_dout: got %h expected 11223344", HOST_DOUT); end
        checks++; if (FIFOEMPTY !== 1'b0) begin errors++; $display("FAIL pack_empty: got %b expected 0", FIFOEMPTY); end
        checks++; if (SCSI_DOUT !== 8'h11) begin errors++; $display("FAIL pack_scsi_dout: got %h expected 11", SCSI_DOUT); end
        INCNO = 1;
        step();
        checks++; if (FIFOEMPTY !== 1'b1) begin errors++; $display("FAIL pack_drain_empty: got %b expected 1", FIFOEMPTY); end
    endtask

    task automatic test_host_write_scsi_read();
        logic [7:0] e [4];
        e[0] = 8'hDE; e[1] = 8'hAD; e[2] = 8'hBE; e[3] = 8'hEF;
        push(32'hDEADBEEF);
        checks++; if (HOST_DOUT !== 32'hDEADBEEF) begin errors++; $display("FAIL hw_host_dout: got %h expected deadbeef", HOST_DOUT); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (SCSI_DOUT !== e[i]) begin errors++; $display("FAIL hw_scsi_dout[%0d]: got %h expected %h", i, SCSI_DOUT, e[i]); end
            INCBO = 1;
            step();
        end
        INCNO = 1;
        step();
        checks++; if (FIFOEMPTY !== 1'b1) begin errors++; $display("FAIL hw_empty: got %b expected 1", FIFOEMPTY); end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            checks++; if (FIFOFULL !== 1'b0) begin errors++; $display("FAIL fill_not_full[%0d]: got %b expected 0", i, FIFOFULL); end
            push(32'(i));
        end
        checks++; if (FIFOFULL !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", FIFOFULL); end
        LHOST = 1; HOST_DIN = 32'hFF;
        step();
        checks++; if (HOST_DOUT !== 32'h0) begin errors++; $display("FAIL fill_suppress: got %h expected 00000000", HOST_DOUT); end
        checks++; if (FIFO_ERR !== EXP_ERR) begin errors++; $display("FAIL fill_err: got %b expected %b", FIFO_ERR, EXP_ERR); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (HOST_DOUT !== 32'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, HOST_DOUT, 32'(i)); end
            INCNO = 1;
            step();
        end
        checks++; if (FIFOEMPTY !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", FIFOEMPTY); end
        // Both pointers wrapped: a new entry lands in, and is read from, slot 0.
        push(32'hA5A5_0001);
        checks++; if (HOST_DOUT !== 32'hA5A5_0001) begin errors++; $display("FAIL wrap_data: got %h expected a5a50001", HOST_DOUT); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        push(32'h10); push(32'h11); push(32'h12);
        LHOST = 1; HOST_DIN = 32'h13; INCNI = 1; INCNO = 1;
        step();
        checks++; if (HOST_DOUT !== 32'h11) begin errors++; $display("FAIL sim_mid_head: got %h expected 00000011", HOST_DOUT); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (HOST_DOUT !== 32'(8'h11 + i)) begin errors++; $display("FAIL sim_mid_data[%0d]: got %h expected %h", i, HOST_DOUT, 32'(8'h11 + i)); end
            checks++; if (FIFOEMPTY !== 1'b0) begin errors++; $display("FAIL sim_mid_count[%0d]: got %b expected 0", i, FIFOEMPTY); end
            INCNO = 1;
            step();
        end
        checks++; if (FIFOEMPTY !== 1'b1) begin errors++; $display("FAIL sim_mid_empty: got %b expected 1", FIFOEMPTY); end
        // Empty: only INCNI takes effect, and it is not a protocol error.
        LHOST = 1; HOST_DIN = 32'h20; INCNI = 1; INCNO = 1;
        step();
        checks++; if (FIFOEMPTY !== 1'b0) begin errors++; $display("FAIL sim_empty_count: got %b expected 0", FIFOEMPTY); end
        checks++; if (HOST_DOUT !== 32'h20) begin errors++; $display("FAIL sim_empty_data: got %h expected 00000020", HOST_DOUT); end
        checks++; if (FIFO_ERR !== 1'b0) begin errors++; $display("FAIL sim_empty_err: got %b expected 0", FIFO_ERR); end
        INCNO = 1;
        step();
        checks++; if (FIFOEMPTY !== 1'b1) begin errors++; $display("FAIL sim_empty_drain: got %b expected 1", FIFOEMPTY); end
        // Full: only INCNO takes effect, count drops to 7.
        for (int i = 0; i < 8; i++) push(32'(8'h30 + i));
        INCNI = 1; INCNO = 1;
        step();
        checks++; if (FIFOFULL !== 1'b0) begin errors++; $display("FAIL sim_full_count: got %b expected 0", FIFOFULL); end
        checks++; if (FIFO_ERR !== 1'b0) begin errors++; $display("FAIL sim_full_err: got %b expected 0", FIFO_ERR); end
        for (int i = 1; i < 8; i++) begin
            checks++; if (HOST_DOUT !== 32'(8'h30 + i)) begin errors++; $display("FAIL sim_full_data[%0d]: got %h expected %h", i, HOST_DOUT, 32'(8'h30 + i)); end
            INCNO = 1;
            step();
        end
        checks++; if (FIFOEMPTY !== 1'b1) begin errors++; $display("FAIL sim_full_empty: got %b expected 1", FIFOEMPTY); end
    endtask

    task automatic test_underflow();
        do_reset();
        INCNO = 1;
        step();
        checks++; if (FIFOEMPTY !== 1'b1) begin errors++; $display("FAIL uf_empty: got %b expected 1", FIFOEMPTY); end
        checks++; if (FIFO_ERR !== EXP_ERR) begin errors++; $display("FAIL uf_err: got %b expected %b", FIFO_ERR, EXP_ERR); end
        push(32'h55);
        checks++; if (HOST_DOUT !== 32'h55) begin errors++; $display("FAIL uf_ptr: got %h expected 00000055", HOST_DOUT); end
    endtask

    // sel: 0 = FLUSH, 1 = RESET, 2 = both
    task automatic test_flush_reset(input int sel);
        do_reset();
        INCNO = 1;
        step();
        for (int i = 0; i < 5; i++) push(32'(8'h60 + i));
        INCBO = 1; step();
        INCBO = 1; step();
        FLUSH = (sel != 1); RESET = (sel != 0);
        step();
        checks++; if (FIFOEMPTY !== 1'b1) begin errors++; $display("FAIL clr%0d_empty: got %b expected 1", sel, FIFOEMPTY); end
        checks++; if (BOEQ3 !== 1'b0) begin errors++; $display("FAIL clr%0d_boeq3: got %b expected 0", sel, BOEQ3); end
        checks++; if (FIFO_ERR !== 1'b0) begin errors++; $display("FAIL clr%0d_err: got %b expected 0", sel, FIFO_ERR); end
        push(32'h01020304);
        checks++; if (SCSI_DOUT !== 8'h01) begin errors++; $display("FAIL clr%0d_bo: got %h expected 01", sel, SCSI_DOUT); end
        INCNO = 1;
        step();
        checks++; if (FIFOEMPTY !== 1'b1) begin errors++; $display("FAIL clr%0d_count: got %b expected 1", sel, FIFOEMPTY); end
    endtask

    initial begin
        idle();
        test_reset();
        test_byte_pack();
        test_host_write_scsi_read();
        test_fill_wrap();
        test_simultaneous();
        test_underflow();
        test_flush_reset(0);
        test_flush_reset(1);
        test_flush_reset(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_scsi_fifo
`default_nettype wire

// File: doc/scsi_fifo.md
Name: scsi_fifo

Overview:
- Longword data FIFO between the SCSI DMA state machine and the host/DMA bus side.
- Packs 8-bit SCSI bytes into 32-bit entries for SCSI→memory transfers.
- Presents 32-bit entries, and the byte lane selected by the byte pointer, for memory→SCSI transfers.
- Owns the next-in/next-out pointers, the 2-bit byte pointer, the entry count and the FIFOFULL/FIFOEMPTY/BOEQ3 status consumed by the state machine.

Parameters:
- DEPTH, 8, number of 32-bit entries; must be a power of two ≥2.
- AW, 3, pointer width = log2(DEPTH).

Ports:
- CPUCLK  in  1  sole clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- FLUSH  in  1  synchronous clear of pointers, count and byte pointer; storage contents are not cleared.
- INCBO  in  1  advance byte pointer.
- INCNI  in  1  commit entry at next-in pointer; advance NI.
- INCNO  in  1  release entry at next-out pointer; advance NO.
- LBYTE_  in  1  active-low; write SCSI_DIN into lane BO of entry NI.
- LHOST  in  1  write HOST_DIN (all 32 bits) into entry NI.
- SCSI_DIN  in  8  byte from SCSI IC.
- HOST_DIN  in  32  longword from CPU/DMA bus.
- HOST_DOUT  out  32  entry at NO, combinational from storage.
- SCSI_DOUT  out  8  lane BO of entry NO, combinational.
- BOEQ3  out  1  BO == 3.
- FIFOFULL  out  1  count == DEPTH.
- FIFOEMPTY  out  1  count == 0.
- FIFO_ERR  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset:
  - Priority: RESET > FLUSH > normal operations.
  - RESET or FLUSH sets NI=0, NO=0, BO=0, count=0, FIFO_ERR=0.
  - Outputs after reset: FIFOEMPTY=1, FIFOFULL=0, BOEQ3=0.
  - Reset mid-transfer discards any partially packed longword. Pointers are not preserved.
- Lane mapping is big-endian 68k: BO=0 → bits 31:24, BO=1 → 23:16, BO=2 → 15:8, BO=3 → 7:0. The same mapping applies to both writes and SCSI_DOUT.
- BO: INCBO increments BO modulo 4 (3→0) independently of NI/NO. It is not auto-cleared by INCNI.
- Data writes (LBYTE_ low or LHOST high) target entry NI and land on the clock edge.
  - Writes are suppressed while FIFOFULL=1, to protect entry NO, which equals NI when full.
  - If LHOST and LBYTE_ are both asserted in the same cycle, LHOST wins and the byte is dropped.
  - A byte write on the same edge as INCBO uses the pre-increment BO.
  - A write on the same edge as INCNI goes to the pre-increment NI.
- Count and pointer updates are evaluated against the current (pre-edge) count:
  - INCNI only: if not full, NI+1 (wraps DEPTH-1→0) and count+1; if full, ignored.
  - INCNO only: if not empty, NO+1 (wraps) and count−1; if empty, ignored.
  - Both, with 0<count<DEPTH: both pointers advance; count unchanged.
  - Both when empty: INCNO ignored; INCNI applies; count becomes 1.
  - Both when full: INCNI ignored; INCNO applies; count becomes DEPTH−1.
- Status: FIFOFULL, FIFOEMPTY and BOEQ3 decode registered state only. They reflect an edge's update in the following cycle, with no combinational input paths.
- Latency: a committed entry is visible on HOST_DOUT/SCSI_DOUT the cycle after the edge on which the write landed.
- Count width is AW+1 bits and never exceeds DEPTH.

Optional Feature:
- Macro: SCSI_FIFO_ERR_EN.
- Defined: FIFO_ERR sets on any edge where INCNI arrives while full (and INCNO is not present), INCNO arrives while empty (and INCNI is not present), or a data write is suppressed by full. It stays set until RESET or FLUSH.
- Not defined: FIFO_ERR is tied to 0 and the detection logic is absent. The port is kept so instantiations are identical in both builds.

Decomposition:
- Package scsi_fifo_pkg holds:
  - DEPTH/AW defaults.
  - BO width (2).
  - Lane-mapping constants (per-BO bit offsets).
  - Function lane_sel(BO) returning the high-bit offset.
- One sub-module, scsi_fifo_ptr, owns NI, NO, count, the full/empty decode, the simultaneous-event rules and the error detection.
- The top level keeps storage, BO, the byte-lane write enables and the output muxes.

Test Plan:
- Byte pack: after reset, drive bytes 0x11, 0x22, 0x33, 0x44, each with LBYTE_=0 and INCBO, then INCNI → HOST_DOUT=0x11223344, FIFOEMPTY=0, BOEQ3 goes 1 after the 3rd INCBO and back to 0 after the 4th.
- Host write/SCSI read: LHOST with 0xDEADBEEF, INCNI; then four INCBO cycles → SCSI_DOUT sequence 0xDE, 0xAD, 0xBE, 0xEF; INCNO → FIFOEMPTY=1.
- Fill/wrap: 8 LHOST+INCNI writes of values 0..7 → FIFOFULL=1. A 9th LHOST of 0xFF is suppressed (HOST_DOUT stays 0) and FIFO_ERR=1 with the macro, 0 without. Drain with 8 INCNO → outputs 0..7 in order, NO wraps to 0.
- Simultaneous: with count=3, assert INCNI+INCNO → count stays 3. With count=0, both → count=1 and FIFOEMPTY=0 next cycle. With count=8, both → count=7.
- Underflow: INCNO while empty → no pointer change, FIFOEMPTY stays 1, FIFO_ERR=1 only with SCSI_FIFO_ERR_EN.
- Reset/flush mid-operation: with count=5 and BO=2, assert FLUSH (also RESET in a separate run) → next cycle count=0, BO=0, FIFOEMPTY=1, FIFO_ERR=0. FLUSH and RESET together behave as RESET.
